seg_scanner: RTL and testbench
==============================

# seg_scanner

Time-multiplexing scanner that sits directly upstream of the per-digit 7-segment decoder. It latches a multi-digit hex value and a digit-enable mask, then cycles through the digits one at a time. For each digit it presents the nibble and decoder enable and drives the active-low anode select. Updates are tear-free: new values are committed only at frame boundaries. A blanking gap between digits prevents ghosting.

## Interface
Parameters:
- DIGITS, 8: number of digits; legal range 1..8.
- SCAN_DIV, 50000: clock cycles each digit is shown; must be ≥1.
- BLANK_CYCLES, 500: clock cycles of all-anodes-off between digits; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load  in  1  single-cycle strobe; captures value and digit_en into pending.
- value  in  4*DIGITS  hex digits; digit i is value[4i+3:4i], and digit 0 is least significant.
- digit_en  in  DIGITS  per-digit enable mask, captured together with value.
- lz_suppress  in  1  live (not latched) leading-zero suppression enable.
- nibble  out  4  current digit code; connects to the decoder in input.
- nibble_en  out  1  decoder enable; connects to the decoder en input.
- an  out  DIGITS  anode select, active-low, one-cold while showing.

## Operation
- Registers:
  - pending value and mask, plus pend_valid flag.
  - committed value and mask.
  - state: BLANK or SHOW.
  - idx: current digit, 0..DIGITS-1.
  - cnt: cycle counter.
- Reset values:
  - state=BLANK, idx=0, cnt=0.
  - committed and pending registers are all 0; pend_valid=0.
  - an=all ones, nibble=0, nibble_en=0.
- load=1 writes value and mask into pending and sets pend_valid. A later load before commit overwrites pending; the last one wins.
- BLANK state:
  - an is all ones and nibble_en=0; nibble holds its previous value.
  - After BLANK_CYCLES cycles, move to SHOW.
- SHOW state:
  - nibble = committed digit idx.
  - an[idx]=0 and all other anode bits are 1, but only when committed mask[idx]=1. If mask[idx]=0, an stays all ones and nibble_en=0.
  - nibble_en=1 when mask[idx]=1 and the digit is not suppressed.
  - After SCAN_DIV cycles, move to BLANK and set idx = (idx+1) mod DIGITS.
- Leading-zero suppression:
  - Digit idx>0 is suppressed when lz_suppress=1 and committed digits idx..DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its anode asserted but has nibble_en=0.
- Frame boundary is the SHOW→BLANK transition out of idx=DIGITS-1.
  - If pend_valid=1, committed ← pending and pend_valid ← 0.
  - If load is asserted on the same edge, the incoming value and mask are committed directly (bypass) and pend_valid stays 0.
- DIGITS=1: every SHOW→BLANK transition is a frame boundary.

## Timing
- All outputs are registered and update on the same edge as the state/idx transition. There is no combinational path from any input to any output.
- Frame period = DIGITS×(SCAN_DIV+BLANK_CYCLES) cycles.
- After reset release, the first SHOW of digit 0 begins BLANK_CYCLES cycles later.
- Load latency: a load's value appears at the first SHOW of digit 0 after the next frame boundary. Worst case is one frame plus BLANK_CYCLES.
- lz_suppress is sampled every cycle. A change takes effect on the next edge while in SHOW.
- Asynchronous reset mid-frame immediately forces all reset values. The pending load is lost.
- cnt width is clog2(max(SCAN_DIV, BLANK_CYCLES)). cnt counts 0..N-1 and wraps to 0 on every state change.

## Structure
- Shared package seg_scan_pkg contains:
  - state encoding constants: BLANK=1'b0, SHOW=1'b1;
  - a clog2 helper;
  - parameter legality checks.
- One natural sub-module: seg_lz_mask. It is purely combinational: it takes the committed value and lz_suppress and returns the per-digit suppress vector.
- The top instantiates seg_scanner feeding one led7seg instance.

## Test plan
Use DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1; frame period is 20 cycles.
- Reset then idle: an=4'b1111 and nibble_en=0 for 40 cycles, because the committed mask is 0 after reset.
- Load value=16'h12AF, mask=4'hF at cycle 3 after reset:
  - first frame still dark;
  - next frame shows F, A, 2, 1;
  - an goes 1110, 1101, 1011, 0111, each for 4 cycles, with a 1-cycle 1111 gap between digits.
- value=16'h0050, mask=4'hF, lz_suppress=1:
  - digits 0 and 1 have nibble_en=1;
  - digits 2 and 3 keep anodes asserted with nibble_en=0;
  - set lz_suppress=0 while in SHOW: digit 3 (nibble 0) has nibble_en=1 on the next edge.
- Two loads in one frame (16'h1111, then 16'h2222): only 2222 is ever displayed. A load on the boundary edge (16'h3333) is displayed in the immediately following frame.
- Mask 4'b0101: an[1] and an[3] are never 0, and nibble_en=0 during their SHOW slots.
- Assert rst_n=0 mid-SHOW of digit 2 with a pending load: outputs return to reset values asynchronously. After release the display stays dark, because the pending load was discarded.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scanner: state encoding,
// width helpers and parameter sanity checks.
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit paramsLegal(input int digits, input int scanDiv, input int blankCycles);
        return (digits >= 1) && (digits <= 8) && (scanDiv >= 1) && (blankCycles >= 1);
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Combinational leading-zero detector: flags each digit above digit 0
// whose value and every more-significant digit are zero.
module seg_lz_mask
    import seg_scan_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [4*DIGITS-1:0] value_i,
    input  logic                lz_suppress_i,
    output logic [DIGITS-1:0]   suppress_o
);

    logic allZero;

    // Walk from the most significant digit down, accumulating "all zero so far".
    always_comb begin
        allZero    = 1'b1;
        suppress_o = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allZero = allZero & (value_i[4*i +: 4] == 4'h0);
            if (i != 0) begin
                suppress_o[i] = lz_suppress_i & allZero;
            end
        end
    end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed digit scanner with tear-free frame-boundary commit,
// inter-digit blanking and live leading-zero suppression.
module seg_scanner
    import seg_scan_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   digit_en,
    input  logic                lz_suppress,
    output logic [3:0]          nibble,
    output logic                nibble_en,
    output logic [DIGITS-1:0]   an
);

    localparam int CNT_W = maxOf(1, clog2(maxOf(SCAN_DIV, BLANK_CYCLES)));
    localparam int IDX_W = maxOf(1, clog2(DIGITS));

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    generate
        if (!paramsLegal(DIGITS, SCAN_DIV, BLANK_CYCLES)) begin : gBadParams
            $error("seg_scanner: DIGITS must be 1..8, SCAN_DIV and BLANK_CYCLES must be >= 1");
        end
    endgenerate

    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] pendValue_q, pendValue_d;
    logic [DIGITS-1:0]   pendMask_q, pendMask_d;
    logic                pendValid_q, pendValid_d;
    logic [4*DIGITS-1:0] commValue_q, commValue_d;
    logic [DIGITS-1:0]   commMask_q, commMask_d;
    logic [3:0]          nibble_q, nibble_d;
    logic                nibbleEn_q, nibbleEn_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [DIGITS-1:0]   suppress;
    logic [3:0]          curNibble;
    logic                curMask;
    logic                curSuppress;
    logic                showDigit;
    logic                frameEnd;

    seg_lz_mask #(
        .DIGITS(DIGITS)
    ) uLzMask (
        .value_i      (commValue_q),
        .lz_suppress_i(lz_suppress),
        .suppress_o   (suppress)
    );

    assign curNibble   = commValue_q[4*idx_q +: 4];
    assign curMask     = commMask_q[idx_q];
    assign curSuppress = suppress[idx_q];

    // Outputs are computed one cycle ahead so they land on the same edge as the state change.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pendValue_d = pendValue_q;
        pendMask_d  = pendMask_q;
        pendValid_d = pendValid_q;
        commValue_d = commValue_q;
        commMask_d  = commMask_q;
        nibble_d    = nibble_q;
        nibbleEn_d  = nibbleEn_q;
        an_d        = an_q;
        showDigit   = 1'b0;
        frameEnd    = 1'b0;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d   = SHOW;
                    cnt_d     = '0;
                    showDigit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d    = BLANK;
                    cnt_d      = '0;
                    idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    frameEnd   = (idx_q == IDX_LAST);
                    an_d       = '1;
                    nibbleEn_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    showDigit = 1'b1;
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase

        if (showDigit) begin
            nibble_d   = curNibble;
            an_d       = curMask ? ~(DIGITS'(1) << idx_q) : '1;
            nibbleEn_d = curMask & ~curSuppress;
        end

        // A load landing exactly on the frame boundary bypasses the pending stage.
        if (frameEnd) begin
            if (load) begin
                commValue_d = value;
                commMask_d  = digit_en;
                pendValid_d = 1'b0;
            end else if (pendValid_q) begin
                commValue_d = pendValue_q;
                commMask_d  = pendMask_q;
                pendValid_d = 1'b0;
            end
        end else if (load) begin
            pendValue_d = value;
            pendMask_d  = digit_en;
            pendValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            pendValue_q <= '0;
            pendMask_q  <= '0;
            pendValid_q <= 1'b0;
            commValue_q <= '0;
            commMask_q  <= '0;
            nibble_q    <= 4'h0;
            nibbleEn_q  <= 1'b0;
            an_q        <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pendValue_q <= pendValue_d;
            pendMask_q  <= pendMask_d;
            pendValid_q <= pendValid_d;
            commValue_q <= commValue_d;
            commMask_q  <= commMask_d;
            nibble_q    <= nibble_d;
            nibbleEn_q  <= nibbleEn_d;
            an_q        <= an_d;
        end
    end

    assign nibble    = nibble_q;
    assign nibble_en = nibbleEn_q;
    assign an        = an_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Self-checking bench for seg_scanner (4 digits, 4-cycle show, 1-cycle blank)
// against a frame-phase reference model.
module tb_seg_scanner;

    localparam int DIGITS = 4;
    localparam int FRAME  = 20;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  digitEn;
    logic        lz;
    logic [3:0]  nibble;
    logic        nibbleEn;
    logic [3:0]  an;

    int testsRun;
    int failCount;

    int          k;
    logic [15:0] mComm;
    logic [3:0]  mCommMask;
    logic [15:0] mPend;
    logic [3:0]  mPendMask;
    bit          mPendValid;
    logic [3:0]  mNibble;
    logic [3:0]  expAn;
    logic [3:0]  expNib;
    logic        expEn;

    bit sawOne, sawTwo, anodeBad, sawAn0, litAny;

    seg_scanner #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .digit_en   (digitEn),
        .lz_suppress(lz),
        .nibble     (nibble),
        .nibble_en  (nibbleEn),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("FAIL %s at edge %0d: observed %0h, expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic modelReset();
        k          = 0;
        mComm      = '0;
        mCommMask  = '0;
        mPend      = '0;
        mPendMask  = '0;
        mPendValid = 1'b0;
        mNibble    = '0;
    endtask

    // Edge k after reset: r=1..4 digit 0, r=5 gap, ... r=16..19 digit 3, r=0 gap (frame end).
    task automatic modelEdge();
        int r;
        int dgt;
        k++;
        r = k % FRAME;
        if (r % 5 == 0) begin
            expAn  = 4'hF;
            expEn  = 1'b0;
            expNib = mNibble;
        end else begin
            dgt     = (r - 1) / 5;
            expNib  = mComm[4*dgt +: 4];
            mNibble = expNib;
            expAn   = mCommMask[dgt] ? ~(4'b0001 << dgt) : 4'hF;
            expEn   = mCommMask[dgt] && !(lz && dgt > 0 && ((mComm >> (4*dgt)) == 16'h0));
        end
        if (r == 0) begin
            if (load) begin
                mComm      = value;
                mCommMask  = digitEn;
                mPendValid = 1'b0;
            end else if (mPendValid) begin
                mComm      = mPend;
                mCommMask  = mPendMask;
                mPendValid = 1'b0;
            end
        end else if (load) begin
            mPend      = value;
            mPendMask  = digitEn;
            mPendValid = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_an"}, 16'(an), 16'(expAn));
        checkVal({tag, "_en"}, 16'(nibbleEn), 16'(expEn));
        checkVal({tag, "_nib"}, 16'(nibble), 16'(expNib));
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("scan");
        if (nibbleEn && nibble == 4'h1) sawOne = 1'b1;
        if (nibbleEn && nibble == 4'h2) sawTwo = 1'b1;
        if (an[1] == 1'b0 || an[3] == 1'b0) anodeBad = 1'b1;
        if (an[0] == 1'b0) sawAn0 = 1'b1;
        if (an != 4'hF || nibbleEn) litAny = 1'b1;
    endtask

    task automatic runTo(input int r);
        int guard;
        guard = 0;
        while ((k % FRAME) != r && guard < 2 * FRAME) begin
            applyStimulus();
            guard++;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_an"}, 16'(an), 16'hF);
        checkVal({tag, "_en"}, 16'(nibbleEn), 16'h0);
        checkVal({tag, "_nib"}, 16'(nibble), 16'h0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("reset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic loadOnce(input logic [15:0] v, input logic [3:0] m);
        value   = v;
        digitEn = m;
        load    = 1'b1;
        applyStimulus();
        load    = 1'b0;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        rst_n     = 1'b1;
        load      = 1'b0;
        value     = '0;
        digitEn   = '0;
        lz        = 1'b0;
        modelReset();
        doReset();

        // Idle after reset: committed mask is zero, so everything stays dark.
        litAny = 1'b0;
        for (int i = 0; i < 40; i++) applyStimulus();
        checkVal("idle_dark", 16'(litAny), 16'h0);

        // Load at cycle 3 after reset; visible in the second frame.
        doReset();
        applyStimulus();
        applyStimulus();
        loadOnce(16'h12AF, 4'hF);
        runTo(1);
        checkVal("first_frame_k", 16'(k), 16'd21);
        checkVal("d0_nibble", 16'(nibble), 16'hF);
        checkVal("d0_an", 16'(an), 16'hE);
        runTo(16);
        checkVal("d3_nibble", 16'(nibble), 16'h1);
        checkVal("d3_an", 16'(an), 16'h7);
        runTo(0);

        // Leading-zero suppression, then live release while showing digit 3.
        lz = 1'b1;
        loadOnce(16'h0050, 4'hF);
        runTo(0);
        runTo(17);
        checkVal("lz_d3_en", 16'(nibbleEn), 16'h0);
        checkVal("lz_d3_an", 16'(an), 16'h7);
        lz = 1'b0;
        applyStimulus();
        checkVal("lz_release_en", 16'(nibbleEn), 16'h1);
        runTo(19);

        // Two loads in one frame: the last wins. Then a load on the boundary edge.
        sawOne = 1'b0;
        sawTwo = 1'b0;
        runTo(2);
        loadOnce(16'h1111, 4'hF);
        runTo(8);
        loadOnce(16'h2222, 4'hF);
        runTo(19);
        applyStimulus();
        runTo(19);
        loadOnce(16'h3333, 4'hF);
        applyStimulus();
        checkVal("bypass_nibble", 16'(nibble), 16'h3);
        checkVal("never_1111", 16'(sawOne), 16'h0);
        checkVal("shown_2222", 16'(sawTwo), 16'h1);

        // Sparse mask: digits 1 and 3 never get an anode.
        runTo(3);
        loadOnce(16'h9876, 4'b0101);
        runTo(0);
        anodeBad = 1'b0;
        sawAn0   = 1'b0;
        for (int i = 0; i < FRAME; i++) applyStimulus();
        checkVal("mask_an13_off", 16'(anodeBad), 16'h0);
        checkVal("mask_an0_on", 16'(sawAn0), 16'h1);

        // Asynchronous reset in the middle of digit 2 with a load pending.
        runTo(5);
        loadOnce(16'hFFFF, 4'hF);
        runTo(0);
        runTo(11);
        loadOnce(16'h8888, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        modelReset();
        @(negedge clk);
        rst_n  = 1'b1;
        litAny = 1'b0;
        for (int i = 0; i < 40; i++) applyStimulus();
        checkVal("dark_after_reset", 16'(litAny), 16'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            load    = ($urandom_range(0, 7) == 0);
            value   = ($urandom_range(0, 1) == 1) ? {8'h00, 8'($urandom)} : 16'($urandom);
            digitEn = 4'($urandom);
            if ($urandom_range(0, 3) == 0) lz = ~lz;
            applyStimulus();
        end
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
